icache: RTL
===========

ICACHE -- requirements
Module: icache

Interface
REQ-001: Parameter SETS, default 16, number of direct-mapped frames of one 32-bit word each; power of two, 2..256.
REQ-002: CLK  input  1  system clock; all state updates on rising edge.
REQ-003: nRST  input  1  asynchronous active-low reset.
REQ-004: imemREN  input  1  datapath instruction read request; level-held until ihit.
REQ-005: imemaddr  input  32  datapath instruction byte address; bits [1:0] ignored.
REQ-006: ihit  output  1  requested word valid on imemload this cycle.
REQ-007: imemload  output  32  instruction word returned to datapath.
REQ-008: iREN  output  1  read request to memory controller.
REQ-009: iaddr  output  32  word-aligned address to memory controller.
REQ-010: iwait  input  1  memory controller busy; iload is valid in a cycle where iREN=1 and iwait=0.
REQ-011: iload  input  32  instruction word from memory controller.
REQ-012: hit_count  output  32  saturating count of hit cycles.
REQ-013: miss_count  output  32  saturating count of misses (fill starts).

Function
REQ-014: Address split: index = imemaddr[2+log2(SETS)-1:2]; tag = imemaddr[31:2+log2(SETS)].
REQ-015: Each frame holds valid bit, tag, 32-bit data.
REQ-016: FSM states: IDLE, FETCH.
REQ-017: IDLE: ihit = imemREN & valid[index] & (tag == stored tag), combinational, same cycle (zero-cycle hit latency).
REQ-018: IDLE: ihit=1 drives imemload = frame data; otherwise imemload = 0.
REQ-019: IDLE, imemREN=1, no hit: latch word-aligned imemaddr into miss_addr, increment miss_count, enter FETCH next edge.
REQ-020: FETCH: iREN=1, iaddr = miss_addr; ihit=0; imemload=0.
REQ-021: FETCH with iwait=0: write iload, miss tag, valid=1 into frame at miss index; return to IDLE next edge.
REQ-022: FETCH with iwait=1: hold state, iREN, iaddr unchanged.
REQ-023: Minimum miss latency: miss detected cycle N, fill cycle N+1 at earliest, ihit asserted cycle N+2.
REQ-024: Changes to imemaddr or deassertion of imemREN during FETCH do not abort fill; latched address is filled; new address evaluated in IDLE.
REQ-025: IDLE: iREN=0, iaddr=0.
REQ-026: Replacement: direct-mapped; fill overwrites frame regardless of prior valid/tag.
REQ-027: No writes from datapath; frame contents change only by fill or reset.
REQ-028: hit_count increments each cycle ihit=1; both counters saturate at 0xFFFFFFFF.
REQ-029: imemREN=0 in IDLE: no state change, ihit=0, counters unchanged.

Reset
REQ-030: nRST low asynchronously forces state IDLE, all valid bits 0, miss_addr 0, counters 0.
REQ-031: Outputs during reset: ihit=0, imemload=0, iREN=0, iaddr=0, hit_count=0, miss_count=0.
REQ-032: Reset during FETCH abandons fill; no frame written; after release first request to same address misses again.
REQ-033: Tag/data arrays need no reset; valid bits gate all hits.

Verification
REQ-034: After reset, imemREN=1, imemaddr=0x00000040, iwait=1 two cycles then 0 with iload=0x8C010004 -> iREN=1 iaddr=0x40 for 3 cycles, miss_count=1, next cycle ihit=1 imemload=0x8C010004, hit_count=1.
REQ-035: Fill 0x00000000 (SETS=16) then request 0x00000040 (same index, different tag) -> miss, iaddr=0x40, frame replaced; re-request 0x0 -> miss again, miss_count=3.
REQ-036: Miss on 0x10, imemaddr changes to 0x20 during FETCH with iwait=1 -> iaddr stays 0x10; after fill, 0x20 misses, 0x10 hits later.
REQ-037: nRST asserted mid-FETCH on 0x8 -> iREN=0 immediately, counters 0; after release, 0x8 misses, iREN=1 iaddr=0x8.
REQ-038: imemaddr=0x00000007 -> iaddr=0x00000004; filled frame hits for 0x4..0x7.
REQ-039: Force hit_count to 0xFFFFFFFE then 3 hit cycles -> hit_count holds 0xFFFFFFFF.

Source files
------------

// File: rtl/icache_if.sv
// Handshake bundle between the datapath, the instruction cache and the memory controller.
// The cache takes the slave view; the datapath and memory side take the master view.
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with zero-cycle hits,
// a two-state miss FSM and saturating hit/miss counters.
module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  icache_if.slave     cif,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t         state;
  logic [SETS-1:0] valid;
  logic [TW-1:0]  tags [SETS];
  logic [31:0]    data [SETS];
  logic [31:0]    miss_addr;

  logic [IW-1:0]  idx;
  logic [IW-1:0]  fidx;
  logic [TW-1:0]  tag;
  logic [TW-1:0]  ftag;
  logic           hit;
  logic           fill;
  logic           unused_ok;

  assign idx  = cif.imemaddr[IW+1:2];
  assign tag  = cif.imemaddr[31:IW+2];
  assign fidx = miss_addr[IW+1:2];
  assign ftag = miss_addr[31:IW+2];

  // Byte offset within the word is irrelevant to a word-granular cache.
  assign unused_ok = &{1'b0, cif.imemaddr[1:0]};

  assign hit  = (state == IDLE) && cif.imemREN && valid[idx] && (tags[idx] == tag);
  assign fill = (state == FETCH) && !cif.iwait;

  assign cif.ihit     = hit;
  assign cif.imemload = hit ? data[idx] : 32'h0;
  assign cif.iREN     = (state == FETCH);
  assign cif.iaddr    = (state == FETCH) ? miss_addr : 32'h0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      valid      <= '0;
      miss_addr  <= 32'h0;
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      if (hit && hit_count != 32'hFFFF_FFFF)
        hit_count <= hit_count + 32'h1;
      case (state)
        IDLE: begin
          if (cif.imemREN && !hit) begin
            miss_addr <= {cif.imemaddr[31:2], 2'b00};
            if (miss_count != 32'hFFFF_FFFF)
              miss_count <= miss_count + 32'h1;
            state <= FETCH;
          end
        end
        FETCH: begin
          // The latched miss address is filled even if the request moved away meanwhile.
          if (!cif.iwait) begin
            valid[fidx] <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone gate hits.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tags[fidx] <= ftag;
      data[fidx] <= cif.iload;
    end
  end

endmodule
